// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access unit for the RV32I core. It acts as a handshaked bus
// master to an external data memory whose latency is not known in advance.
// It handles byte, halfword and word loads and stores, with sign or zero
// extension on loads and byte enables on both loads and stores. It flags
// misaligned accesses and illegal funct3 values. While an access is in flight
// it stalls the F/D/E/M pipeline registers, and it passes the M-stage sideband
// signals through to writeback.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   valid_m_i               M-stage instruction valid
//   alu_result_m_i          effective address
//   write_data_m_i          unaligned store data (rs2)
//   mem_read_m_i            load instruction
//   mem_write_m_i           store instruction
//   funct3_m_i              access size / signedness
//   reg_write_m_i, result_src_m_i, rd_m_i, pc_plus_4_m_i
//                           sideband in; passed through to the *_m_o outputs
//                           (reg_write is suppressed on a fault)
//   read_data_m_o           registered, extended load result
//   stall_m_o               hold the F/D/E/M pipeline registers
//   fault_m_o               misaligned access or illegal funct3
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
//                           bus request channel
//   mem_ready_i             request accepted
//   mem_rvalid_i            read data valid
//   mem_rdata_i             raw read word
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_m_i,
    input  logic [WIDTH-1:0]      alu_result_m_i,
    input  logic [WIDTH-1:0]      write_data_m_i,
    input  logic                  mem_read_m_i,
    input  logic                  mem_write_m_i,
    input  logic [2:0]            funct3_m_i,
    input  logic                  reg_write_m_i,
    input  logic [1:0]            result_src_m_i,
    input  logic [4:0]            rd_m_i,
    input  logic [WIDTH-1:0]      pc_plus_4_m_i,
    output logic                  reg_write_m_o,
    output logic [1:0]            result_src_m_o,
    output logic [4:0]            rd_m_o,
    output logic [WIDTH-1:0]      pc_plus_4_m_o,
    output logic [WIDTH-1:0]      read_data_m_o,
    output logic                  stall_m_o,
    output logic                  fault_m_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addrLow;
    logic [WIDTH-1:0] r_readData;

    logic             w_isAccess;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_fault;
    logic             w_legal;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_loadExt;

    // Decode the instruction currently in M. BU/HU exist only for loads,
    // so a store using them is treated like any other illegal encoding.
    // Faults are only reported from IDLE; once an access has been accepted
    // the inputs are held stable and are known to be legal.
    always_comb begin
        w_isAccess = valid_m_i & (mem_read_m_i ^ mem_write_m_i);
        case (funct3_m_i)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = mem_write_m_i;
            default:                w_illegal = 1'b1;
        endcase
        w_misaligned = ((funct3_m_i[1:0] == 2'b01) & alu_result_m_i[0])
                     | ((funct3_m_i == 3'b010) & (alu_result_m_i[1:0] != 2'b00));
        w_fault = (r_state == IDLE) & w_isAccess & (w_illegal | w_misaligned);
        w_legal = w_isAccess & ~w_illegal & ~w_misaligned;
    end

    // Byte lanes and replicated store data, driven the same way for loads
    // and stores so the memory sees a consistent enable pattern.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data_m_i;
        case (funct3_m_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_result_m_i[1:0];
                w_wdata = {4{write_data_m_i[7:0]}};
            end
            2'b01: begin
                w_be    = alu_result_m_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data_m_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data_m_i;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word using the
    // latched address, then extend according to the latched funct3.
    always_comb begin
        case (r_addrLow)
            2'd0:    w_byte = mem_rdata_i[7:0];
            2'd1:    w_byte = mem_rdata_i[15:8];
            2'd2:    w_byte = mem_rdata_i[23:16];
            default: w_byte = mem_rdata_i[31:24];
        endcase
        w_half = r_addrLow[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadExt = {24'b0, w_byte};
            3'b101:  w_loadExt = {16'b0, w_half};
            default: w_loadExt = mem_rdata_i;
        endcase
    end

    // Access sequencer. IDLE latches the request, REQ holds it on the bus
    // until accepted, WAIT_R waits for load data, DONE releases the stall for
    // exactly one cycle so the stage advances before the next access starts.
    // A zero-latency read (ready and rvalid together in REQ) skips WAIT_R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_funct3    <= 3'b000;
            r_addrLow   <= 2'b00;
            r_readData  <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_funct3    <= funct3_m_i;
                        r_addrLow   <= alu_result_m_i[1:0];
                        mem_we_o    <= mem_write_m_i;
                        mem_addr_o  <= {alu_result_m_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_o <= w_wdata;
                        mem_be_o    <= w_be;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        if (mem_we_o) begin
                            r_state <= DONE;
                        end else if (mem_rvalid_i) begin
                            r_readData <= w_loadExt;
                            r_state    <= DONE;
                        end else begin
                            r_state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid_i) begin
                        r_readData <= w_loadExt;
                        r_state    <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the IDLE cycle in which a legal access is first seen,
    // plus every REQ and WAIT_R cycle; DONE lets the pipeline move.
    always_comb begin
        mem_req_o = (r_state == REQ);
        stall_m_o = ((r_state == IDLE) & w_legal) | (r_state == REQ) | (r_state == WAIT_R);
        fault_m_o = w_fault;
    end

    // Sideband pass-through; a faulting instruction must not write back.
    always_comb begin
        reg_write_m_o  = reg_write_m_i & ~w_fault;
        result_src_m_o = result_src_m_i;
        rd_m_o         = rd_m_i;
        pc_plus_4_m_o  = pc_plus_4_m_i;
        read_data_m_o  = r_readData;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipelined memory-stage access unit for the RV32I core. It replaces the single-cycle, word-only data-memory path with a handshaked bus master to an external data memory of arbitrary latency. It supports byte, halfword and word loads and stores with sign or zero extension and byte enables, and detects misaligned accesses. It stalls the pipeline while an access is outstanding and passes the M-stage sideband signals through to writeback.

## Interface
Parameters:
- WIDTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 32, width of the address driven on mem_addr_o; taken from the low bits of alu_result_m_i.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_m_i  in  1  M-stage instruction valid.
- alu_result_m_i  in  WIDTH  effective address.
- write_data_m_i  in  WIDTH  store data, unaligned (rs2).
- mem_read_m_i  in  1  load instruction.
- mem_write_m_i  in  1  store instruction.
- funct3_m_i  in  3  access size and signedness.
- reg_write_m_i / result_src_m_i[1:0] / rd_m_i[4:0] / pc_plus_4_m_i[WIDTH]  in  sideband.
- reg_write_m_o / result_src_m_o / rd_m_o / pc_plus_4_m_o  out  sideband, combinational pass-through.
- read_data_m_o  out  WIDTH  extended load result, registered.
- stall_m_o  out  1  hold the F/D/E/M pipeline registers.
- fault_m_o  out  1  misaligned access or illegal funct3.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  write request.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, with the low 2 bits forced to 0.
- mem_wdata_o  out  WIDTH  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_ready_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  WIDTH  raw read word.

## Operation
- An access occurs when valid_m_i is 1 and exactly one of mem_read_m_i or mem_write_m_i is 1.
- funct3 encodings:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - BU and HU are legal for loads only.
  - All other encodings are illegal.
- Misaligned accesses:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] ≠ 0.
- On a fault: no bus request, fault_m_o = 1 for the cycle, reg_write_m_o is forced to 0, and stall_m_o = 0.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: be = 0011 when addr[1] = 0, 1100 when addr[1] = 1; wdata = {2{half}}.
  - SW: be = 1111.
- Load extraction: select the byte or halfword by addr[1:0] from mem_rdata_i, then sign-extend (B, H) or zero-extend (BU, HU). W is unchanged.
- Loads drive mem_be_o according to size, the same way as stores.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE: on a legal access, latch the address, lanes, we and funct3, then go to REQ.
  - REQ: mem_req_o = 1 with the latched values held stable.
    - On mem_ready_i: a store goes to DONE; a load goes to WAIT_R.
    - If mem_ready_i and mem_rvalid_i are both 1 in REQ (zero-latency read), capture the data and go directly to DONE.
  - WAIT_R: on mem_rvalid_i, register the extended data into read_data_m_o and go to DONE.
  - DONE: the access is complete and the stage advances. Return to IDLE.
- stall_m_o = 1 when (IDLE and a legal access is present) or in REQ or in WAIT_R. It is 0 in DONE.
- Upstream holds all *_m_i inputs stable while stall_m_o = 1.
- mem_rvalid_i outside REQ or WAIT_R is ignored.
- Non-access instructions pass through with stall_m_o = 0. read_data_m_o keeps its last value.

## Timing
- Reset (asynchronous, rst_n = 0):
  - State → IDLE.
  - read_data_m_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o → 0.
  - stall_m_o and fault_m_o follow the inputs combinationally from IDLE.
  - A reset asserted mid-access abandons the request immediately. A late mem_rvalid_i after reset is ignored.
- Minimum store latency is 3 cycles (IDLE, REQ, DONE), with 2 stall cycles.
- Minimum load latency is 3 cycles (zero-latency read) or 4 cycles (rvalid one cycle after ready).
- Each cycle in REQ without mem_ready_i adds one stall cycle. Each cycle in WAIT_R without mem_rvalid_i adds one stall cycle.
- read_data_m_o is valid in DONE and stays stable until the next load completes.
- Back-to-back accesses: after DONE there is one IDLE cycle before the next REQ. mem_req_o is never asserted in two distinct accesses without an intervening deassertion.

## Test plan
- Reset mid-WAIT_R: assert rst_n = 0 → mem_req_o = 0 and state = IDLE; a subsequent mem_rvalid_i = 1 leaves read_data_m_o = 0.
- SB to addr 0x1003 with data 0x000000A5 → mem_be_o = 1000, mem_wdata_o = 0xA5A5A5A5, mem_addr_o = 0x1000; stall is high for 2 cycles.
- Load from addr 0x2002 with mem_rdata_i = 0x80F01234:
  - LH → read_data_m_o = 0xFFFF80F0.
  - LHU → read_data_m_o = 0x000080F0.
  - LB at 0x2003 → read_data_m_o = 0xFFFFFF80.
- LW at 0x3000 with mem_ready_i delayed 3 cycles and mem_rvalid_i 2 cycles later → stall_m_o high for exactly 6 cycles, then DONE with read_data_m_o = mem_rdata_i.
- SW at 0x4002, or funct3 = 011 → fault_m_o = 1, mem_req_o stays 0, stall_m_o = 0, reg_write_m_o = 0.
- Zero-latency read (mem_ready_i and mem_rvalid_i both 1 in REQ), followed immediately by a store → load completes in 3 cycles; the store's REQ begins only after one IDLE cycle.
